// File: rtl/msft_dv_ip_fifo_wm_if.sv
// Bus bundle between a FIFO owner (CSR block or serial engine) and the
// msft_dv_ip_fifo_wm buffer. Signal suffixes are relative to the FIFO.
interface msft_dv_ip_fifo_wm_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  flush_i;
  logic                  wr_i;
  logic [FIFO_WIDTH-1:0] wdata_i;
  logic                  rd_i;
  logic [FIFO_WIDTH-1:0] rdata_o;
  logic                  full_o;
  logic                  empty_o;
  logic [CNT_W-1:0]      lvl_o;
  logic [CNT_W-1:0]      afull_thr_i;
  logic [CNT_W-1:0]      aempty_thr_i;
  logic                  afull_o;
  logic                  aempty_o;
  logic                  ovr_run_o;
  logic                  udr_run_o;
  logic                  ovr_sticky_o;
  logic                  udr_sticky_o;
  logic                  clr_err_i;

  modport master (
    output flush_i, wr_i, wdata_i, rd_i, afull_thr_i, aempty_thr_i, clr_err_i,
    input  rdata_o, full_o, empty_o, lvl_o, afull_o, aempty_o,
           ovr_run_o, udr_run_o, ovr_sticky_o, udr_sticky_o
  );

  modport slave (
    input  flush_i, wr_i, wdata_i, rd_i, afull_thr_i, aempty_thr_i, clr_err_i,
    output rdata_o, full_o, empty_o, lvl_o, afull_o, aempty_o,
           ovr_run_o, udr_run_o, ovr_sticky_o, udr_sticky_o
  );
endinterface

// File: rtl/msft_dv_ip_fifo_wm.sv
// Show-ahead synchronous FIFO with arbitrary depth, flush, live watermarks
// and sticky overrun/underrun flags. Occupancy is tracked by an explicit level.
module msft_dv_ip_fifo_wm #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  msft_dv_ip_fifo_wm_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(FIFO_DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  ptr_t                  r_hp;
  ptr_t                  r_tp;
  cnt_t                  r_lvl;
  logic                  r_ovr_sticky;
  logic                  r_udr_sticky;

  logic w_full, w_empty, w_wr_ok, w_rd_ok, w_ovr, w_udr;
  ptr_t w_hp_nxt, w_tp_nxt;

  assign w_full   = (r_lvl == DEPTH_C);
  assign w_empty  = (r_lvl == '0);
  assign w_wr_ok  = bus.wr_i & ~w_full  & ~bus.flush_i;
  assign w_rd_ok  = bus.rd_i & ~w_empty & ~bus.flush_i;
  assign w_ovr    = bus.wr_i & w_full  & ~bus.flush_i;
  assign w_udr    = bus.rd_i & w_empty & ~bus.flush_i;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign w_hp_nxt = (r_hp == LAST_PTR) ? '0 : r_hp + ptr_t'(1);
  assign w_tp_nxt = (r_tp == LAST_PTR) ? '0 : r_tp + ptr_t'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hp         <= '0;
      r_tp         <= '0;
      r_lvl        <= '0;
      r_ovr_sticky <= 1'b0;
      r_udr_sticky <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        r_hp  <= '0;
        r_tp  <= '0;
        r_lvl <= '0;
      end else begin
        if (w_wr_ok) r_hp <= w_hp_nxt;
        if (w_rd_ok) r_tp <= w_tp_nxt;
        case ({w_wr_ok, w_rd_ok})
          2'b10:   r_lvl <= r_lvl + cnt_t'(1);
          2'b01:   r_lvl <= r_lvl - cnt_t'(1);
          default: r_lvl <= r_lvl;
        endcase
      end
      // Set has priority over clear; flush leaves the flags alone.
      r_ovr_sticky <= w_ovr | (r_ovr_sticky & ~bus.clr_err_i);
      r_udr_sticky <= w_udr | (r_udr_sticky & ~bus.clr_err_i);
    end
  end

  // NOTE: storage is deliberately not reset; the level register alone decides
  // validity, and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) r_mem[r_hp] <= bus.wdata_i;
  end

  assign bus.rdata_o      = r_mem[r_tp];
  assign bus.full_o       = w_full;
  assign bus.empty_o      = w_empty;
  assign bus.lvl_o        = r_lvl;
  assign bus.afull_o      = (r_lvl >= bus.afull_thr_i);
  assign bus.aempty_o     = (r_lvl <= bus.aempty_thr_i);
  assign bus.ovr_run_o    = w_ovr;
  assign bus.udr_run_o    = w_udr;
  assign bus.ovr_sticky_o = r_ovr_sticky;
  assign bus.udr_sticky_o = r_udr_sticky;
endmodule

// File: tb/tb_msft_dv_ip_fifo_wm.sv
// Directed bench for msft_dv_ip_fifo_wm at depth 5 / width 12: a vector table
// for the basic fill/drain flow plus hand sequences for multi-cycle corners.
module tb_msft_dv_ip_fifo_wm;
  localparam int W = 12;
  localparam int D = 5;

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  msft_dv_ip_fifo_wm_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  msft_dv_ip_fifo_wm #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {full, empty, afull, aempty, ovr_run, udr_run, ovr_sticky, udr_sticky}
  typedef struct {
    logic         wr;
    logic [W-1:0] wd;
    logic         rd;
    logic         clr;
    logic [2:0]   e_lvl;
    logic         chk_rd;
    logic [W-1:0] e_rd;
    logic [7:0]   e_flg;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] flags();
    return {bus.full_o, bus.empty_o, bus.afull_o, bus.aempty_o,
            bus.ovr_run_o, bus.udr_run_o, bus.ovr_sticky_o, bus.udr_sticky_o};
  endfunction

  task automatic set_in(input logic wr, input logic [W-1:0] wd, input logic rd,
                        input logic fl, input logic clr);
    bus.wr_i      = wr;
    bus.wdata_i   = wd;
    bus.rd_i      = rd;
    bus.flush_i   = fl;
    bus.clr_err_i = clr;
  endtask

  // Advance through one rising edge, landing on the following falling edge.
  task automatic step();
    @(negedge clk);
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [W-1:0] wd);
    set_in(1'b1, wd, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic pop();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] seq;

  initial begin
    vecs = '{
      //  wr    wd      rd    clr   lvl   chk   rdata   flags
      '{1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0000},
      '{1'b1, 12'h001, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0000},
      '{1'b1, 12'h002, 1'b0, 1'b0, 3'd1, 1'b1, 12'h001, 8'b0001_0000},
      '{1'b1, 12'h003, 1'b0, 1'b0, 3'd2, 1'b1, 12'h001, 8'b0000_0000},
      '{1'b1, 12'h004, 1'b0, 1'b0, 3'd3, 1'b1, 12'h001, 8'b0000_0000},
      '{1'b1, 12'h005, 1'b0, 1'b0, 3'd4, 1'b1, 12'h001, 8'b0010_0000},
      '{1'b1, 12'h006, 1'b0, 1'b0, 3'd5, 1'b1, 12'h001, 8'b1010_1000},
      '{1'b0, 12'h000, 1'b0, 1'b0, 3'd5, 1'b1, 12'h001, 8'b1010_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd5, 1'b1, 12'h001, 8'b1010_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd4, 1'b1, 12'h002, 8'b0010_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd3, 1'b1, 12'h003, 8'b0000_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd2, 1'b1, 12'h004, 8'b0000_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd1, 1'b1, 12'h005, 8'b0001_0010},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0110},
      '{1'b0, 12'h000, 1'b0, 1'b1, 3'd0, 1'b0, 12'h000, 8'b0101_0011},
      '{1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0000},
      '{1'b1, 12'h0AA, 1'b1, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0100},
      '{1'b0, 12'h000, 1'b0, 1'b0, 3'd1, 1'b1, 12'h0AA, 8'b0001_0001},
      '{1'b0, 12'h000, 1'b1, 1'b0, 3'd1, 1'b1, 12'h0AA, 8'b0001_0001},
      '{1'b0, 12'h000, 1'b1, 1'b1, 3'd0, 1'b0, 12'h000, 8'b0101_0101},
      '{1'b0, 12'h000, 1'b0, 1'b1, 3'd0, 1'b0, 12'h000, 8'b0101_0001},
      '{1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000, 8'b0101_0000}
    };

    rstn             = 1'b0;
    bus.afull_thr_i  = 3'd4;
    bus.aempty_thr_i = 3'd1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Table: fill with overrun, drain with underrun, sticky clear, empty rd+wr.
    foreach (vecs[i]) begin
      set_in(vecs[i].wr, vecs[i].wd, vecs[i].rd, 1'b0, vecs[i].clr);
      #1;
      check($sformatf("vec%0d_lvl", i), 32'(bus.lvl_o), 32'(vecs[i].e_lvl));
      check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].e_flg));
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), 32'(bus.rdata_o), 32'(vecs[i].e_rd));
      step();
    end

    // Simultaneous rd+wr at level 3 keeps the level; at full only the read lands.
    push(12'h011); push(12'h022); push(12'h033);
    set_in(1'b1, 12'h044, 1'b1, 1'b0, 1'b0);
    #1 check("mid_rdwr_head", 32'(bus.rdata_o), 32'h011);
    step();
    #1 check("mid_rdwr_lvl", 32'(bus.lvl_o), 32'd3);
    check("mid_rdwr_next", 32'(bus.rdata_o), 32'h022);
    push(12'h055); push(12'h066);
    #1 check("full_before_rdwr", 32'(bus.full_o), 32'd1);
    set_in(1'b1, 12'h077, 1'b1, 1'b0, 1'b0);
    #1 check("full_rdwr_ovr", 32'(bus.ovr_run_o), 32'd1);
    step();
    #1 check("full_rdwr_lvl", 32'(bus.lvl_o), 32'd4);
    check("full_rdwr_head", 32'(bus.rdata_o), 32'h033);
    check("full_rdwr_sticky", 32'(bus.ovr_sticky_o), 32'd1);

    // Flush at full with a write pending: no pulse, FIFO empties.
    push(12'h088);
    set_in(1'b1, 12'h099, 1'b0, 1'b1, 1'b0);
    #1 check("flush_full_ovr", 32'(bus.ovr_run_o), 32'd0);
    step();
    #1 check("flush_full_lvl", 32'(bus.lvl_o), 32'd0);

    // Flush at level 4 leaves a previously latched underrun flag set.
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1 check("flush_rd_udr", 32'(bus.udr_run_o), 32'd0);
    step();
    pop();
    push(12'h101); push(12'h102); push(12'h103); push(12'h104);
    #1 check("pre_flush_lvl", 32'(bus.lvl_o), 32'd4);
    check("pre_flush_udrs", 32'(bus.udr_sticky_o), 32'd1);
    set_in(1'b1, 12'h105, 1'b0, 1'b1, 1'b0);
    #1 check("flush_ovr", 32'(bus.ovr_run_o), 32'd0);
    step();
    #1 check("flush_lvl", 32'(bus.lvl_o), 32'd0);
    check("flush_empty", 32'(bus.empty_o), 32'd1);
    check("flush_udrs_kept", 32'(bus.udr_sticky_o), 32'd1);
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();

    // Watermarks across the full range with afull_thr=4, aempty_thr=1.
    for (int l = 0; l <= D; l++) begin
      #1;
      check($sformatf("wm%0d_lvl", l), 32'(bus.lvl_o), 32'(l));
      check($sformatf("wm%0d_afull", l), 32'(bus.afull_o), 32'(l >= 4));
      check($sformatf("wm%0d_aempty", l), 32'(bus.aempty_o), 32'(l <= 1));
      if (l < D) push(12'h200 + 12'(l));
    end
    bus.aempty_thr_i = 3'd7;
    #1 check("wm_aempty_thr7_full", 32'(bus.aempty_o), 32'd1);
    bus.aempty_thr_i = 3'd1;
    pop(); pop();
    #1 check("wm_l3_afull_thr4", 32'(bus.afull_o), 32'd0);
    bus.afull_thr_i = 3'd2;
    #1 check("wm_l3_afull_thr2", 32'(bus.afull_o), 32'd1);
    bus.afull_thr_i = 3'd4;

    // Asynchronous reset mid-cycle at level 3.
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("arst_lvl", 32'(bus.lvl_o), 32'd0);
    check("arst_flags", 32'(flags()), 32'b0101_0000);
    @(negedge clk);
    rstn = 1'b1;
    bus.afull_thr_i = 3'd0;
    #1 check("wm_thr0_afull_l0", 32'(bus.afull_o), 32'd1);
    bus.afull_thr_i = 3'd4;

    // Wrap: 100 random push/pop cycles against a queue model.
    q.delete();
    seq = 12'h300;
    for (int c = 0; c < 100; c++) begin
      automatic logic wr = 1'($urandom_range(0, 1));
      automatic logic rd = 1'($urandom_range(0, 1));
      automatic logic wr_ok, rd_ok;
      set_in(wr, seq, rd, 1'b0, 1'b0);
      #1;
      check($sformatf("wrap%0d_lvl", c), 32'(bus.lvl_o), 32'(q.size()));
      if (q.size() > 0)
        check($sformatf("wrap%0d_rdata", c), 32'(bus.rdata_o), 32'(q[0]));
      wr_ok = wr && (q.size() < D);
      rd_ok = rd && (q.size() > 0);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) begin
        q.push_back(seq);
        seq = seq + 12'd1;
      end
      step();
    end
    #1 check("wrap_final_lvl", 32'(bus.lvl_o), 32'(q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/msft_dv_ip_fifo_wm.md
Name: msft_dv_ip_fifo_wm

Overview:
- Parametrised synchronous show-ahead FIFO; next generation of the 8-bit/8-deep serial-peripheral FIFO.
- Adds the following over the previous generation:
  - configurable data width;
  - depth that need not be a power of two;
  - synchronous flush;
  - programmable almost-full/almost-empty watermarks;
  - sticky overrun/underrun error flags.
- Sits between the register-bus CSR block and the serial engines (I2C/SPI/UART) as both TX and RX buffer.

Parameters:
- FIFO_WIDTH, 8, data bits per entry (≥1).
- FIFO_DEPTH, 8, number of entries (≥2, any integer).
- CNT_W, $clog2(FIFO_DEPTH+1), width of level/threshold fields; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset.
- flush_i  in  1  synchronous flush; empties FIFO.
- wr_i  in  1  write request.
- wdata_i  in  FIFO_WIDTH  write data.
- rd_i  in  1  read request (pop).
- rdata_o  out  FIFO_WIDTH  head entry, valid when empty_o=0.
- full_o  out  1  level == FIFO_DEPTH.
- empty_o  out  1  level == 0.
- lvl_o  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- afull_thr_i  in  CNT_W  almost-full threshold.
- aempty_thr_i  in  CNT_W  almost-empty threshold.
- afull_o  out  1  lvl_o >= afull_thr_i.
- aempty_o  out  1  lvl_o <= aempty_thr_i.
- ovr_run_o  out  1  this-cycle overrun pulse (wr_i & full_o & ~flush_i).
- udr_run_o  out  1  this-cycle underrun pulse (rd_i & empty_o & ~flush_i).
- ovr_sticky_o  out  1  latched overrun.
- udr_sticky_o  out  1  latched underrun.
- clr_err_i  in  1  clears both sticky flags.

Behaviour:
- Reset and clock: reset rstn_i, asynchronous, active-low; clock clk_i.
- Reset state:
  - head and tail pointers are 0;
  - level register is 0;
  - sticky flags are 0.
  - Therefore empty_o=1, full_o=0, lvl_o=0, ovr/udr outputs 0.
  - afull_o and aempty_o follow their combinational definitions with lvl_o=0.
- Storage: not reset; rdata_o is undefined while empty.
- State held:
  - head pointer hp, tail pointer tp, each in 0..FIFO_DEPTH-1;
  - explicit level register of CNT_W bits.
  - full/empty derive from the level, not from pointer overflow bits, so non-power-of-two depths work.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0 (explicit compare, no modulo-2^n).
- Show-ahead read: rdata_o = mem[tp] combinationally, with zero latency. The pop takes effect at the clock edge.
- Write accept (wr_ok) = wr_i & ~full_o & ~flush_i.
  - mem[hp] <= wdata_i; hp advances.
- Read accept (rd_ok) = rd_i & ~empty_o & ~flush_i.
  - tp advances.
- Level update:
  - +1 if wr_ok & ~rd_ok;
  - -1 if rd_ok & ~wr_ok;
  - unchanged otherwise.
- Full with simultaneous rd_i and wr_i:
  - the read is accepted and the write is rejected (full_o gates the write with no read bypass);
  - ovr_run_o=1; level goes to FIFO_DEPTH-1.
- Empty with simultaneous rd_i and wr_i:
  - the write is accepted and the read is rejected (no write-through);
  - udr_run_o=1; level goes to 1.
- Non-full, non-empty with simultaneous rd_i and wr_i: both are accepted and the level is unchanged.
- Flush:
  - next edge sets hp=tp=0 and level=0;
  - any same-cycle rd_i/wr_i is ignored, and neither pulse nor sticky flag is set;
  - sticky flags are not cleared by flush.
- Sticky flags:
  - each is set on the edge after its pulse;
  - cleared by clr_err_i;
  - if set and clear occur in the same cycle, set wins.
- Watermarks:
  - purely combinational unsigned compares on lvl_o, with thresholds taken live;
  - thr=0 makes afull_o constantly 1;
  - aempty_thr_i >= FIFO_DEPTH makes aempty_o constantly 1.
- Reset mid-operation: all pointers, level and flags return to reset values immediately (asynchronous). Contents are discarded logically.

Test Plan:
- Depth 5, width 12: write 0x001..0x005 → full_o=1 and lvl_o=5 after 5th edge. 6th write 0x006 gives ovr_run_o=1 and ovr_sticky_o=1; reads then return 0x001..0x005 in order, and empty_o=1 after the 5th pop.
- Wrap, depth 5: 100 interleaved push/pop cycles with a sequence counter. Scoreboard shows no loss or reorder, and lvl_o tracks the reference model every cycle.
- Simultaneous rd+wr:
  - at level 5 (full): level goes to 4 and ovr_run_o=1;
  - at level 0: level goes to 1 and udr_run_o=1; the written word then appears on rdata_o;
  - at level 3: level stays 3.
- Flush: fill to 4, assert flush_i with wr_i=1 → next cycle lvl_o=0, empty_o=1, ovr_run_o=0. Previously set udr_sticky_o stays 1.
- Watermarks: afull_thr_i=4, aempty_thr_i=1. Fill 0→5: aempty_o=1 at levels 0-1, afull_o=1 at levels 4-5. Changing afull_thr_i to 2 at level 3 raises afull_o the same cycle.
- Sticky clear and reset: clr_err_i asserted together with a new underrun leaves udr_sticky_o=1. clr_err_i alone clears it. rstn_i dropped at level 3 mid-cycle gives lvl_o=0 and empty_o=1 asynchronously.
